fetch_sequencer: RTL and testbench

Instruction fetch/issue controller that sequences the multicycle processor from a program memory. It holds the program counter, reads 16-bit instruction words from a synchronous single-port memory, and presents them on the processor's `DIN` with `Run` asserted. For `mvi` it supplies the immediate word in the processor's second time step, waits for `Done`, then advances to the next instruction. It sits between program memory and the processor; the processor is unmodified.

---
 rtl/proc_pkg.sv | 35 +++
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  proc_pkg
//  Shared definitions for the multicycle processor and its fetch sequencer:
//  opcode encodings, the sequencer state encoding and the data word width.
//  Revision: 1.0
// ============================================================================
package proc_pkg;

    localparam int WORD_W = 16;

    // Opcode field occupies DIN[3:0] of an instruction word.
    localparam logic [3:0] OP_MV  = 4'b0000;
    localparam logic [3:0] OP_MVI = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_LD  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_IMM    = 3'd4,
        ST_EXEC   = 3'd5,
        ST_HALTED = 3'd6,
        ST_FAULT  = 3'd7
    } seq_state_t;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  fetch_sequencer
//  Fetches 16-bit instruction words from a synchronous program memory and
//  issues them to the multicycle processor (DIN + Run). For mvi the
//  immediate word is streamed straight from memory in the second time step.
//  Retirement is signalled by Done; a watchdog faults a stalled instruction.
//
//  Ports:
//    Clock, Resetn      clock (rising edge), asynchronous active-low reset
//    Go                 start / resume / single-step pulse (idle states only)
//    Halt               level; stop at the next instruction boundary
//    MemAddr, MemRd     program memory address and read strobe
//    MemData            program memory read data (valid cycle after MemRd)
//    DIN, Run           word and run enable towards the processor
//    Done               processor end-of-instruction
//    Busy, Fault        status: sequencing active / watchdog expired
//    PC, InstrCount     current instruction address / retired count
//  Revision: 1.0
// ============================================================================
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int WDOG_MAX = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Go,
    input  logic              Halt,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRd,
    input  logic [15:0]       MemData,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Fault,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       InstrCount
);

    localparam int WDOG_W = $clog2(WDOG_MAX + 1);
    localparam logic [ADDR_W-1:0] C_RESET_PC  = ADDR_W'(RESET_PC);
    localparam logic [WDOG_W-1:0] C_WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

    seq_state_t          r_state_q,  w_state_d;
    logic [ADDR_W-1:0]   r_pc_q,     w_pc_d;
    logic [WORD_W-1:0]   r_instr_q,  w_instr_d;
    logic [WORD_W-1:0]   r_din_q,    w_din_d;
    logic [WDOG_W-1:0]   r_wdog_q,   w_wdog_d;
    logic [15:0]         r_icount_q, w_icount_d;

    logic                w_is_mvi;
    logic [ADDR_W-1:0]   w_pc_plus1;

    assign w_is_mvi   = (r_instr_q[3:0] == OP_MVI);
    assign w_pc_plus1 = r_pc_q + ADDR_W'(1);

    always_comb begin
        w_state_d  = r_state_q;
        w_pc_d     = r_pc_q;
        w_instr_d  = r_instr_q;
        w_din_d    = r_din_q;
        w_icount_d = r_icount_q;
        w_wdog_d   = '0;            // watchdog only runs while in EXEC

        unique case (r_state_q)
            ST_IDLE: begin
                if (Go) w_state_d = ST_FETCH;
            end
            ST_FETCH: begin
                w_state_d = ST_LOAD;
            end
            ST_LOAD: begin
                w_instr_d = MemData;
                w_din_d   = MemData;
                w_state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // The processor latches IR from the held instruction here.
                w_din_d   = r_instr_q;
                w_state_d = w_is_mvi ? ST_IMM : ST_EXEC;
            end
            ST_IMM: begin
                // Keep the immediate on DIN for the rest of the instruction.
                w_din_d   = MemData;
                w_state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // Done takes priority over a simultaneous watchdog expiry.
                if (Done) begin
                    w_pc_d     = w_is_mvi ? (r_pc_q + ADDR_W'(2)) : w_pc_plus1;
                    w_icount_d = r_icount_q + 16'd1;
                    w_state_d  = Halt ? ST_HALTED : ST_FETCH;
                end else if (r_wdog_q == C_WDOG_LAST) begin
                    w_state_d = ST_FAULT;
                end else begin
                    w_wdog_d = r_wdog_q + WDOG_W'(1);
                end
            end
            ST_HALTED, ST_FAULT: begin
                // Halt still high on resume gives a single step, since EXEC
                // returns to HALTED when it retires the instruction.
                if (Go) w_state_d = ST_FETCH;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state_q  <= ST_IDLE;
            r_pc_q     <= C_RESET_PC;
            r_instr_q  <= '0;
            r_din_q    <= '0;
            r_wdog_q   <= '0;
            r_icount_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_instr_q  <= w_instr_d;
            r_din_q    <= w_din_d;
            r_wdog_q   <= w_wdog_d;
            r_icount_q <= w_icount_d;
        end
    end

    // Outputs decode directly from the state register.
    assign Run        = (r_state_q == ST_ISSUE) || (r_state_q == ST_IMM) ||
                        (r_state_q == ST_EXEC);
    assign MemRd      = (r_state_q == ST_FETCH) ||
                        ((r_state_q == ST_ISSUE) && w_is_mvi);
    assign MemAddr    = ((r_state_q == ST_ISSUE) && w_is_mvi) ? w_pc_plus1 : r_pc_q;
    assign DIN        = (r_state_q == ST_IMM) ? MemData : r_din_q;
    assign Busy       = !((r_state_q == ST_IDLE) || (r_state_q == ST_HALTED) ||
                          (r_state_q == ST_FAULT));
    assign Fault      = (r_state_q == ST_FAULT);
    assign PC         = r_pc_q;
    assign InstrCount = r_icount_q;

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_fetch_sequencer
//  Directed bench for fetch_sequencer: program memory model plus a linear
//  sequence of steps where the bench itself plays the processor's Done.
//  Revision: 1.0
// ============================================================================
module tb_fetch_sequencer;

    logic        Clock;
    logic        Resetn;
    logic        Go;
    logic        Halt;
    logic [7:0]  MemAddr;
    logic        MemRd;
    logic [15:0] MemData;
    logic [15:0] DIN;
    logic        Run;
    logic        Done;
    logic        Busy;
    logic        Fault;
    logic [7:0]  PC;
    logic [15:0] InstrCount;

    logic [15:0] mem [0:255];

    int n_vec;
    int n_err;

    fetch_sequencer #(
        .ADDR_W   (8),
        .RESET_PC (0),
        .WDOG_MAX (8)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Go         (Go),
        .Halt       (Halt),
        .MemAddr    (MemAddr),
        .MemRd      (MemRd),
        .MemData    (MemData),
        .DIN        (DIN),
        .Run        (Run),
        .Done       (Done),
        .Busy       (Busy),
        .Fault      (Fault),
        .PC         (PC),
        .InstrCount (InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous single-port program memory.
    always @(posedge Clock) begin
        if (MemRd) MemData <= mem[MemAddr];
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        Resetn = 1'b0;
        Go     = 1'b0;
        Halt   = 1'b0;
        Done   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[4] = 16'h0011;
        mem[5] = 16'hBEEF;

        #12;
        chk("rst_run",    Run,        0);
        chk("rst_memrd",  MemRd,      0);
        chk("rst_memaddr",MemAddr,    0);
        chk("rst_din",    DIN,        0);
        chk("rst_busy",   Busy,       0);
        chk("rst_fault",  Fault,      0);
        chk("rst_pc",     PC,         0);
        chk("rst_icount", InstrCount, 0);
        Resetn = 1'b1;
        tick();

        // ---- mv at 0, Done one cycle after ISSUE ----
        Go = 1'b1;                                 // cycle 0 (IDLE)
        chk("c0_memrd", MemRd, 0);
        tick(); Go = 1'b0;                         // cycle 1 FETCH
        chk("c1_memrd", MemRd, 1);
        chk("c1_run",   Run,   0);
        chk("c1_busy",  Busy,  1);
        tick();                                    // cycle 2 LOAD
        chk("c2_memrd", MemRd, 0);
        chk("c2_run",   Run,   0);
        tick();                                    // cycle 3 ISSUE
        chk("c3_run",   Run,   1);
        chk("c3_din",   DIN,   16'h0000);
        tick();                                    // cycle 4 EXEC
        chk("c4_run",   Run,   1);
        Done = 1'b1;
        tick(); Done = 1'b0;                       // cycle 5 FETCH
        chk("c5_run",     Run,        0);
        chk("c5_memrd",   MemRd,      1);
        chk("c5_memaddr", MemAddr,    1);
        chk("c5_pc",      PC,         1);
        chk("c5_icount",  InstrCount, 1);

        // ---- Halt stops after the mv at 1 ----
        Halt = 1'b1;
        tick(); tick(); tick();                    // LOAD, ISSUE, EXEC
        Done = 1'b1;
        tick(); Done = 1'b0;                       // HALTED
        chk("halt_busy",   Busy,       0);
        chk("halt_run",    Run,        0);
        chk("halt_pc",     PC,         2);
        chk("halt_icount", InstrCount, 2);

        // ---- single steps of mv at 2 and 3 ----
        for (int s = 0; s < 2; s++) begin
            Go = 1'b1;
            tick(); Go = 1'b0;                     // FETCH
            tick(); tick(); tick();                // LOAD, ISSUE, EXEC
            Done = 1'b1;
            tick(); Done = 1'b0;                   // HALTED
        end
        chk("step_busy",   Busy,       0);
        chk("step_pc",     PC,         4);
        chk("step_icount", InstrCount, 4);

        // ---- mvi at 4, immediate 0xBEEF ----
        Go = 1'b1;
        tick(); Go = 1'b0;                         // FETCH
        chk("mvi_fetch_addr", MemAddr, 4);
        tick();                                    // LOAD
        tick();                                    // ISSUE
        chk("mvi_issue_din",   DIN,     16'h0011);
        chk("mvi_issue_addr",  MemAddr, 5);
        chk("mvi_issue_memrd", MemRd,   1);
        tick();                                    // IMM
        chk("mvi_imm_din",   DIN,   16'hBEEF);
        chk("mvi_imm_run",   Run,   1);
        chk("mvi_imm_memrd", MemRd, 0);
        tick();                                    // EXEC
        chk("mvi_exec_din", DIN, 16'hBEEF);
        Done = 1'b1;
        tick(); Done = 1'b0;
        chk("mvi_pc",     PC,         6);
        chk("mvi_icount", InstrCount, 5);
        chk("mvi_busy",   Busy,       0);

        // ---- free run of mv from 6 up to 0xFE, Done held high ----
        mem[8'hFF] = 16'h0011;
        mem[8'h00] = 16'h1234;
        Halt = 1'b0;
        Done = 1'b1;
        Go   = 1'b1;
        tick(); Go = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (PC == 8'hFE) break;
            tick();
        end
        chk("run_reach_fe", PC, 8'hFE);
        Halt = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!Busy) break;
            tick();
        end
        Done = 1'b0;
        chk("run_busy",   Busy,       0);
        chk("run_pc",     PC,         8'hFF);
        chk("run_icount", InstrCount, 254);

        // ---- mvi at 0xFF wraps immediate read to 0x00 ----
        Go = 1'b1;
        tick(); Go = 1'b0;                         // FETCH
        chk("wrap_fetch_addr", MemAddr, 8'hFF);
        tick();                                    // LOAD
        tick();                                    // ISSUE
        chk("wrap_issue_addr", MemAddr, 8'h00);
        chk("wrap_issue_din",  DIN,     16'h0011);
        tick();                                    // IMM
        chk("wrap_imm_din", DIN, 16'h1234);
        tick();                                    // EXEC
        Done = 1'b1;
        tick(); Done = 1'b0;
        chk("wrap_pc",     PC,         8'h01);
        chk("wrap_icount", InstrCount, 255);

        // ---- watchdog: no Done for 8 EXEC cycles ----
        Go = 1'b1;
        tick(); Go = 1'b0;                         // FETCH
        tick(); tick(); tick();                    // LOAD, ISSUE, EXEC1
        for (int k = 1; k <= 8; k++) begin
            chk("wdog_exec_run", Run, 1);
            Go = (k == 4);                         // Go while Busy is ignored
            tick();
        end
        Go = 1'b0;
        chk("wdog_fault",  Fault,      1);
        chk("wdog_run",    Run,        0);
        chk("wdog_busy",   Busy,       0);
        chk("wdog_pc",     PC,         1);
        chk("wdog_icount", InstrCount, 255);
        tick();
        chk("wdog_fault_hold", Fault, 1);
        Go = 1'b1;
        tick(); Go = 1'b0;                         // FETCH at same PC
        chk("clr_fault",   Fault,   0);
        chk("clr_memaddr", MemAddr, 1);
        chk("clr_memrd",   MemRd,   1);
        tick(); tick(); tick();                    // LOAD, ISSUE, EXEC
        Done = 1'b1;
        tick(); Done = 1'b0;
        chk("clr_pc",     PC,         2);
        chk("clr_icount", InstrCount, 256);

        // ---- Done coinciding with the last watchdog cycle retires ----
        Go = 1'b1;
        tick(); Go = 1'b0;                         // FETCH
        tick(); tick(); tick();                    // LOAD, ISSUE, EXEC1
        for (int k = 1; k <= 7; k++) tick();       // EXEC8
        chk("edge_run", Run, 1);
        Done = 1'b1;
        tick(); Done = 1'b0;
        chk("edge_fault",  Fault,      0);
        chk("edge_busy",   Busy,       0);
        chk("edge_pc",     PC,         3);
        chk("edge_icount", InstrCount, 257);

        // ---- asynchronous reset during IMM ----
        mem[3] = 16'h0011;
        mem[4] = 16'h5A5A;
        Go = 1'b1;
        tick(); Go = 1'b0;                         // FETCH
        tick(); tick(); tick();                    // LOAD, ISSUE, IMM
        chk("ar_imm_din", DIN, 16'h5A5A);
        #2 Resetn = 1'b0;
        #1;
        chk("ar_run",     Run,        0);
        chk("ar_din",     DIN,        0);
        chk("ar_pc",      PC,         0);
        chk("ar_memaddr", MemAddr,    0);
        chk("ar_memrd",   MemRd,      0);
        chk("ar_busy",    Busy,       0);
        chk("ar_icount",  InstrCount, 0);
        #2 Resetn = 1'b1;

        // ---- Done while IDLE is ignored ----
        Done = 1'b1;
        tick(); tick();
        Done = 1'b0;
        chk("idle_done_busy",  Busy,       0);
        chk("idle_done_run",   Run,        0);
        chk("idle_done_memrd", MemRd,      0);
        chk("idle_done_pc",    PC,         0);
        chk("idle_done_icnt",  InstrCount, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fetch_sequencer
`default_nettype wire
